// File: rtl/esfa_trial_scheduler_if.sv
// Command, statistics and engine-control bundle between the host decoder, the
// trial scheduler and the ESFATop run engine.
interface esfa_trial_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmdValid;
  logic [CNT_W-1:0] cmdTrials;
  logic             cmdAbort;
  logic             cmdReady;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             doRun;
  logic             isRunning;
  logic             wasSuccessful;
  logic [31:0]      currentAddr;
  logic [CNT_W-1:0] trialsDone;
  logic [CNT_W-1:0] successCount;
  logic [CNT_W-1:0] timeoutCount;
  logic [CNT_W-1:0] startFailCount;
  logic [31:0]      lastAddr;

  // Scheduler side.
  modport slave (
    input  cmdValid, cmdTrials, cmdAbort, isRunning, wasSuccessful, currentAddr,
    output cmdReady, busy, done, aborted, doRun,
           trialsDone, successCount, timeoutCount, startFailCount, lastAddr
  );

  // Host and engine side.
  modport master (
    output cmdValid, cmdTrials, cmdAbort, isRunning, wasSuccessful, currentAddr,
    input  cmdReady, busy, done, aborted, doRun,
           trialsDone, successCount, timeoutCount, startFailCount, lastAddr
  );
endinterface

// File: rtl/esfa_trial_scheduler.sv
// Runs a batch of engine trials back-to-back under start/run watchdogs and
// accumulates per-batch statistics; sole driver of the engine doRun request.
module esfa_trial_scheduler #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned START_WAIT     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TMR_W          = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  esfa_trial_scheduler_if.slave bus
);

  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_WAIT - 1);
  localparam logic [TMR_W-1:0] RUN_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_SAMPLE, S_DRAIN, S_NEXT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   trials_q, trials_d;
  logic [CNT_W-1:0]   succ_q, succ_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   sfail_q, sfail_d;
  logic [31:0]        last_addr_q, last_addr_d;
  logic               aborted_q, aborted_d;
  logic               do_run_q, cmd_ready_q, busy_q, done_q;
  logic               abort_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Abort only matters while a batch is in flight.
  assign abort_c = bus.cmdAbort &&
                   (state_q inside {S_START, S_RUN, S_SAMPLE, S_DRAIN, S_NEXT});

  // Next-state and statistics update.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    rem_d       = rem_q;
    trials_d    = trials_q;
    succ_d      = succ_q;
    tmo_d       = tmo_q;
    sfail_d     = sfail_q;
    last_addr_d = last_addr_q;
    aborted_d   = aborted_q;

    if (abort_c) begin
      state_d   = S_DONE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmdValid) begin
            rem_d     = bus.cmdTrials;
            trials_d  = '0;
            succ_d    = '0;
            tmo_d     = '0;
            sfail_d   = '0;
            aborted_d = 1'b0;
            tmr_d     = '0;
            state_d   = (bus.cmdTrials == '0) ? S_DONE : S_START;
          end
        end
        S_START: begin
          if (bus.isRunning) begin
            tmr_d   = '0;
            state_d = S_RUN;
          end else if (tmr_q == START_LAST) begin
            sfail_d = sat_inc(sfail_q);
            state_d = S_NEXT;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_RUN: begin
          // A fall coinciding with the timeout still counts as a normal finish.
          if (!bus.isRunning) begin
            state_d = S_SAMPLE;
          end else if (tmr_q == RUN_LAST) begin
            tmo_d   = sat_inc(tmo_q);
            state_d = S_DRAIN;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_SAMPLE: begin
          if (bus.wasSuccessful) succ_d = sat_inc(succ_q);
          last_addr_d = bus.currentAddr;
          state_d     = S_NEXT;
        end
        S_DRAIN: begin
          if (!bus.isRunning) state_d = S_NEXT;
        end
        S_NEXT: begin
          trials_d = sat_inc(trials_q);
          rem_d    = rem_q - CNT_W'(1);
          tmr_d    = '0;
          state_d  = (rem_q == CNT_W'(1)) ? S_DONE : S_START;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counters and outputs registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      rem_q       <= '0;
      trials_q    <= '0;
      succ_q      <= '0;
      tmo_q       <= '0;
      sfail_q     <= '0;
      last_addr_q <= '0;
      aborted_q   <= 1'b0;
      do_run_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      rem_q       <= rem_d;
      trials_q    <= trials_d;
      succ_q      <= succ_d;
      tmo_q       <= tmo_d;
      sfail_q     <= sfail_d;
      last_addr_q <= last_addr_d;
      aborted_q   <= aborted_d;
      do_run_q    <= (state_d == S_START);
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= !(state_d inside {S_IDLE, S_DONE});
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.doRun          = do_run_q;
  assign bus.cmdReady       = cmd_ready_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.aborted        = aborted_q;
  assign bus.trialsDone     = trials_q;
  assign bus.successCount   = succ_q;
  assign bus.timeoutCount   = tmo_q;
  assign bus.startFailCount = sfail_q;
  assign bus.lastAddr       = last_addr_q;

endmodule
